execute_ldst_access: RTL and testbench
======================================

Name: execute_ldst_access

Overview:
- Downstream of the execute adder/address stage. Consumes the LDST pipe bundle: RW, PDT, ADDR, DATA, ORDER, MASK, LOAD_SHIFT.
- Issues one access at a time to the data-memory port, waits for the response, then aligns and extends load data.
- Hands the result to writeback through a valid/busy handshake.
- Raises an alignment fault instead of accessing memory when the request is illegal.

Parameters:
- P_ALIGN_CHECK, 1, 1 = misaligned or empty-mask requests fault with no memory access; 0 = pass through unchecked.

Ports:
- iCLOCK  in  1  core clock
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous clear, same effect as reset
- iFLUSH  in  1  pipeline flush
- iPREV_VALID  in  1  request valid
- oPREV_BUSY  out  1  stage cannot accept a request
- iPREV_RW  in  1  0 = load, 1 = store
- iPREV_SIGNED  in  1  load sign-extend
- iPREV_DEST  in  5  writeback register tag
- iPREV_PDT  in  32  page directory table base
- iPREV_ADDR  in  32  byte address
- iPREV_DATA  in  32  lane-positioned store data
- iPREV_ORDER  in  2  0 = byte, 1 = half, 2 = word
- iPREV_MASK  in  4  byte enable
- iPREV_SHIFT  in  2  load byte-lane shift
- oDATAIO_REQ  out  1  memory request
- iDATAIO_BUSY  in  1  memory not accepting
- oDATAIO_RW  out  1
- oDATAIO_PDT  out  32
- oDATAIO_ADDR  out  32
- oDATAIO_DATA  out  32
- oDATAIO_ORDER  out  2
- oDATAIO_MASK  out  4
- iDATAIO_VALID  in  1  response
- iDATAIO_DATA  in  32  raw read word
- oNEXT_VALID  out  1  result valid
- iNEXT_BUSY  in  1  writeback stall
- oNEXT_DATA  out  32  aligned load data; 0 for stores
- oNEXT_DEST  out  5
- oNEXT_RW  out  1
- oNEXT_FAULT  out  1  alignment fault

Behaviour:
- Reset (inRESET low, asynchronous) or iRESET_SYNC: state IDLE; all outputs 0; internal request/result registers 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - oPREV_BUSY = 0.
  - On iPREV_VALID && !iFLUSH, capture the whole bundle.
  - If P_ALIGN_CHECK and the request is illegal -> DONE with FAULT = 1 and no memory access. Illegal means any of: ORDER == 3; MASK == 0; ORDER == 1 && ADDR[0]; ORDER == 2 && ADDR[1:0] != 0.
  - Otherwise -> ISSUE.
- ISSUE:
  - oDATAIO_REQ = 1, with oDATAIO_* driven from the captured registers.
  - Handshake completes in the cycle oDATAIO_REQ && !iDATAIO_BUSY -> WAIT.
  - iFLUSH before that handshake -> IDLE; request dropped, no result.
- WAIT:
  - Held until iDATAIO_VALID. The response may arrive in the first WAIT cycle or later; there is no timeout.
  - On response, compute the result and go -> DONE.
  - If a flush was seen in WAIT, or in the same cycle as the handshake, set a discard flag. The response is still consumed, then -> IDLE with no oNEXT_VALID.
- Load alignment: w = iDATAIO_DATA >> (8*SHIFT).
  - ORDER 0: w[7:0], extended with bit 7 if SIGNED, else zeros.
  - ORDER 1: w[15:0], extended likewise from bit 15.
  - ORDER 2: full word.
- Stores also wait for iDATAIO_VALID as the write acknowledge; oNEXT_DATA = 0.
- DONE:
  - oNEXT_VALID = 1; result registers held stable while iNEXT_BUSY.
  - Leaves to IDLE in the first cycle !iNEXT_BUSY.
  - iFLUSH in DONE -> IDLE immediately, oNEXT_VALID dropped next cycle.
- oPREV_BUSY = (state != IDLE). No back-to-back acceptance in the DONE exit cycle.
- Minimum latency: accept at cycle 0, oDATAIO_REQ at cycle 1; zero-wait response at cycle 2 gives oNEXT_VALID at cycle 3. A fault path gives oNEXT_VALID at cycle 1.
- Simultaneous iFLUSH and iPREV_VALID in IDLE: request ignored.
- iDATAIO_VALID outside WAIT: ignored.

Decomposition:
- Shared package/header (core.h):
  - ORDER encodings (BYTE = 0, HALF = 1, WORD = 2).
  - State encodings for IDLE/ISSUE/WAIT/DONE.
  - RW encoding (LOAD = 0, STORE = 1).
- One natural combinational sub-module: execute_ldst_load_align (raw word, SHIFT, ORDER, SIGNED -> aligned 32-bit data).
- The alignment checker stays inline.

Test Plan:
- Load byte, signed: ADDR 0x1003, SHIFT 3, ORDER 0, SIGNED 1; memory returns 0x80AABBCC with zero wait -> oNEXT_DATA 0xFFFFFF80, oNEXT_VALID at cycle 3.
- Load half, unsigned: ADDR 0x2002, SHIFT 2, ORDER 1; response 0x8001_1234 -> oNEXT_DATA 0x00008001.
- Store word: ADDR 0x3000, DATA 0xDEADBEEF, MASK 0xF; iDATAIO_BUSY held 3 cycles -> oDATAIO_* stable throughout; single handshake; oNEXT_RW 1, oNEXT_DATA 0.
- Misaligned word: ADDR 0x4002, ORDER 2 -> oDATAIO_REQ never asserted; oNEXT_VALID at cycle 1 with oNEXT_FAULT 1.
- Flush in WAIT: load issued, iFLUSH pulsed, response 2 cycles later -> no oNEXT_VALID; next request accepted afterwards with the correct result.
- Writeback stall and reset: iNEXT_BUSY held 4 cycles -> oNEXT_DATA/oNEXT_DEST stable; inRESET dropped in WAIT -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/execute_ldst_access_pkg.sv
// ---------------------------------------------------------------------------
// execute_ldst_access_pkg
// Shared encodings for the LDST access stage: FSM states, access order,
// read/write direction, the captured request / result bundles, and the
// alignment legality check used at request acceptance.
// ---------------------------------------------------------------------------
package execute_ldst_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ldst_state_t;

    localparam logic [1:0] ORDER_BYTE = 2'd0;
    localparam logic [1:0] ORDER_HALF = 2'd1;
    localparam logic [1:0] ORDER_WORD = 2'd2;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef struct packed {
        logic        rw;
        logic        sign_ext;
        logic [4:0]  dest;
        logic [31:0] pdt;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic [1:0]  shift;
    } ldst_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        rw;
        logic        fault;
    } ldst_res_t;

    // Order 3 is unused, an empty mask would access nothing, and half/word
    // accesses must sit on their natural boundary.
    function automatic logic ldst_illegal(input logic [1:0] order,
                                          input logic [3:0] mask,
                                          input logic [1:0] addr_lo);
        ldst_illegal = (order == 2'd3)
                    || (mask == 4'd0)
                    || ((order == ORDER_HALF) && addr_lo[0])
                    || ((order == ORDER_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/execute_ldst_access_load_align.sv
// ---------------------------------------------------------------------------
// execute_ldst_load_align
// Combinational load-data aligner: moves the addressed byte lane down to
// bit 0 and zero- or sign-extends it according to the access order.
//   raw_data     in  32  raw word returned by data memory
//   shift        in  2   byte-lane shift
//   order        in  2   byte / half / word
//   sign_ext     in  1   sign-extend byte and half loads
//   aligned_data out 32  right-justified, extended load value
// ---------------------------------------------------------------------------
module execute_ldst_load_align
    import execute_ldst_access_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [1:0]  shift,
    input  logic [1:0]  order,
    input  logic        sign_ext,
    output logic [31:0] aligned_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = raw_data >> {shift, 3'b000};
        case (order)
            ORDER_BYTE: aligned_data = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
            ORDER_HALF: aligned_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default:    aligned_data = shifted;
        endcase
    end

endmodule

// File: rtl/execute_ldst_access.sv
// ---------------------------------------------------------------------------
// execute_ldst_access
// LDST access stage. Accepts one request from the address stage, issues it
// to the data-memory port, waits for the response (read data or write
// acknowledge), aligns load data and presents the result to writeback.
// Illegal requests fault straight to the result without touching memory.
//
// State table
//   state | meaning
//   IDLE  | ready, captures a request when iPREV_VALID && !iFLUSH
//   ISSUE | oDATAIO_REQ high until the memory port accepts it
//   WAIT  | request accepted, waiting for iDATAIO_VALID
//   DONE  | result valid to writeback, held while iNEXT_BUSY
//
// Ports
//   iCLOCK, inRESET (async, active low), iRESET_SYNC, iFLUSH
//   iPREV_*   request bundle in,  oPREV_BUSY back-pressure out
//   oDATAIO_* memory request out, iDATAIO_BUSY/VALID/DATA in
//   oNEXT_*   result to writeback, iNEXT_BUSY stall in
// ---------------------------------------------------------------------------
module execute_ldst_access
    import execute_ldst_access_pkg::*;
#(
    parameter bit P_ALIGN_CHECK = 1'b1
)(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,

    input  logic        iPREV_VALID,
    output logic        oPREV_BUSY,
    input  logic        iPREV_RW,
    input  logic        iPREV_SIGNED,
    input  logic [4:0]  iPREV_DEST,
    input  logic [31:0] iPREV_PDT,
    input  logic [31:0] iPREV_ADDR,
    input  logic [31:0] iPREV_DATA,
    input  logic [1:0]  iPREV_ORDER,
    input  logic [3:0]  iPREV_MASK,
    input  logic [1:0]  iPREV_SHIFT,

    output logic        oDATAIO_REQ,
    input  logic        iDATAIO_BUSY,
    output logic        oDATAIO_RW,
    output logic [31:0] oDATAIO_PDT,
    output logic [31:0] oDATAIO_ADDR,
    output logic [31:0] oDATAIO_DATA,
    output logic [1:0]  oDATAIO_ORDER,
    output logic [3:0]  oDATAIO_MASK,
    input  logic        iDATAIO_VALID,
    input  logic [31:0] iDATAIO_DATA,

    output logic        oNEXT_VALID,
    input  logic        iNEXT_BUSY,
    output logic [31:0] oNEXT_DATA,
    output logic [4:0]  oNEXT_DEST,
    output logic        oNEXT_RW,
    output logic        oNEXT_FAULT
);

    ldst_state_t state;
    ldst_req_t   req;
    ldst_res_t   res;
    logic        discard;
    logic [31:0] load_data;

    execute_ldst_load_align u_load_align (
        .raw_data     (iDATAIO_DATA),
        .shift        (req.shift),
        .order        (req.order),
        .sign_ext     (req.sign_ext),
        .aligned_data (load_data)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state   <= ST_IDLE;
            req     <= '0;
            res     <= '0;
            discard <= 1'b0;
        end else if (iRESET_SYNC) begin
            state   <= ST_IDLE;
            req     <= '0;
            res     <= '0;
            discard <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iPREV_VALID && !iFLUSH) begin
                        req.rw       <= iPREV_RW;
                        req.sign_ext <= iPREV_SIGNED;
                        req.dest     <= iPREV_DEST;
                        req.pdt      <= iPREV_PDT;
                        req.addr     <= iPREV_ADDR;
                        req.data     <= iPREV_DATA;
                        req.order    <= iPREV_ORDER;
                        req.mask     <= iPREV_MASK;
                        req.shift    <= iPREV_SHIFT;
                        discard      <= 1'b0;
                        if (P_ALIGN_CHECK &&
                            ldst_illegal(iPREV_ORDER, iPREV_MASK, iPREV_ADDR[1:0])) begin
                            res.data  <= '0;
                            res.dest  <= iPREV_DEST;
                            res.rw    <= iPREV_RW;
                            res.fault <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Once the port has taken the request its response must
                    // still be drained, so a same-cycle flush only marks it.
                    if (!iDATAIO_BUSY) begin
                        discard <= iFLUSH;
                        state   <= ST_WAIT;
                    end else if (iFLUSH) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (iDATAIO_VALID) begin
                        if (discard || iFLUSH) begin
                            state <= ST_IDLE;
                        end else begin
                            res.data  <= (req.rw == RW_STORE) ? 32'd0 : load_data;
                            res.dest  <= req.dest;
                            res.rw    <= req.rw;
                            res.fault <= 1'b0;
                            state     <= ST_DONE;
                        end
                    end else if (iFLUSH) begin
                        discard <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (iFLUSH || !iNEXT_BUSY) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oPREV_BUSY    = (state != ST_IDLE);
    assign oDATAIO_REQ   = (state == ST_ISSUE);
    assign oDATAIO_RW    = req.rw;
    assign oDATAIO_PDT   = req.pdt;
    assign oDATAIO_ADDR  = req.addr;
    assign oDATAIO_DATA  = req.data;
    assign oDATAIO_ORDER = req.order;
    assign oDATAIO_MASK  = req.mask;

    assign oNEXT_VALID   = (state == ST_DONE);
    assign oNEXT_DATA    = res.data;
    assign oNEXT_DEST    = res.dest;
    assign oNEXT_RW      = res.rw;
    assign oNEXT_FAULT   = res.fault;

endmodule

// File: tb/tb_execute_ldst_access.sv
module tb_execute_ldst_access;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iRESET_SYNC;
    logic        iFLUSH;
    logic        iPREV_VALID;
    logic        oPREV_BUSY;
    logic        iPREV_RW;
    logic        iPREV_SIGNED;
    logic [4:0]  iPREV_DEST;
    logic [31:0] iPREV_PDT;
    logic [31:0] iPREV_ADDR;
    logic [31:0] iPREV_DATA;
    logic [1:0]  iPREV_ORDER;
    logic [3:0]  iPREV_MASK;
    logic [1:0]  iPREV_SHIFT;
    logic        oDATAIO_REQ;
    logic        iDATAIO_BUSY;
    logic        oDATAIO_RW;
    logic [31:0] oDATAIO_PDT;
    logic [31:0] oDATAIO_ADDR;
    logic [31:0] oDATAIO_DATA;
    logic [1:0]  oDATAIO_ORDER;
    logic [3:0]  oDATAIO_MASK;
    logic        iDATAIO_VALID;
    logic [31:0] iDATAIO_DATA;
    logic        oNEXT_VALID;
    logic        iNEXT_BUSY;
    logic [31:0] oNEXT_DATA;
    logic [4:0]  oNEXT_DEST;
    logic        oNEXT_RW;
    logic        oNEXT_FAULT;

    int tests = 0;
    int fails = 0;

    execute_ldst_access dut (
        .iCLOCK        (iCLOCK),
        .inRESET       (inRESET),
        .iRESET_SYNC   (iRESET_SYNC),
        .iFLUSH        (iFLUSH),
        .iPREV_VALID   (iPREV_VALID),
        .oPREV_BUSY    (oPREV_BUSY),
        .iPREV_RW      (iPREV_RW),
        .iPREV_SIGNED  (iPREV_SIGNED),
        .iPREV_DEST    (iPREV_DEST),
        .iPREV_PDT     (iPREV_PDT),
        .iPREV_ADDR    (iPREV_ADDR),
        .iPREV_DATA    (iPREV_DATA),
        .iPREV_ORDER   (iPREV_ORDER),
        .iPREV_MASK    (iPREV_MASK),
        .iPREV_SHIFT   (iPREV_SHIFT),
        .oDATAIO_REQ   (oDATAIO_REQ),
        .iDATAIO_BUSY  (iDATAIO_BUSY),
        .oDATAIO_RW    (oDATAIO_RW),
        .oDATAIO_PDT   (oDATAIO_PDT),
        .oDATAIO_ADDR  (oDATAIO_ADDR),
        .oDATAIO_DATA  (oDATAIO_DATA),
        .oDATAIO_ORDER (oDATAIO_ORDER),
        .oDATAIO_MASK  (oDATAIO_MASK),
        .iDATAIO_VALID (iDATAIO_VALID),
        .iDATAIO_DATA  (iDATAIO_DATA),
        .oNEXT_VALID   (oNEXT_VALID),
        .iNEXT_BUSY    (iNEXT_BUSY),
        .oNEXT_DATA    (oNEXT_DATA),
        .oNEXT_DEST    (oNEXT_DEST),
        .oNEXT_RW      (oNEXT_RW),
        .oNEXT_FAULT   (oNEXT_FAULT)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: pick the addressed lane arithmetically, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] raw, input int shift,
                                               input int order, input bit sgn);
        longint v;
        longint w;
        w = longint'(raw) / (longint'(1) << (8 * shift));
        case (order)
            0: begin v = w % 256;   if (sgn && v >= 128)   v = v - 256;   end
            1: begin v = w % 65536; if (sgn && v >= 32768) v = v - 65536; end
            default: v = w;
        endcase
        return v[31:0];
    endfunction

    function automatic bit model_fault(input int order, input int mask, input int addr_lo);
        if (order == 3 || mask == 0) return 1'b1;
        if (order == 1 && (addr_lo % 2) == 1) return 1'b1;
        if (order == 2 && addr_lo != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic present(input bit rw, input bit sgn, input logic [4:0] dest,
                           input logic [31:0] pdt, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] order,
                           input logic [3:0] mask, input logic [1:0] shift);
        iPREV_RW = rw; iPREV_SIGNED = sgn; iPREV_DEST = dest; iPREV_PDT = pdt;
        iPREV_ADDR = addr; iPREV_DATA = data; iPREV_ORDER = order;
        iPREV_MASK = mask; iPREV_SHIFT = shift; iPREV_VALID = 1'b1;
        tick();
        iPREV_VALID = 1'b0;
        iPREV_ADDR = $urandom;
        iPREV_DATA = $urandom;
    endtask

    // Full transaction starting from IDLE, ending back in IDLE.
    task automatic transact(input string tag, input bit rw, input bit sgn,
                            input logic [4:0] dest, input logic [31:0] pdt,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] order, input logic [3:0] mask,
                            input logic [1:0] shift, input logic [31:0] raw,
                            input int mem_busy, input int resp_delay, input int wb_busy);
        bit          flt;
        logic [31:0] exp_data;
        flt = model_fault(int'(order), int'(mask), int'(addr[1:0]));
        exp_data = (flt || rw) ? 32'd0 : model_load(raw, int'(shift), int'(order), sgn);
        present(rw, sgn, dest, pdt, addr, data, order, mask, shift);
        chk({tag, ".busy_acc"}, oPREV_BUSY, 1);
        if (flt) begin
            chk({tag, ".flt_noreq"}, oDATAIO_REQ, 0);
        end else begin
            chk({tag, ".req"}, oDATAIO_REQ, 1);
            chk({tag, ".nv_issue"}, oNEXT_VALID, 0);
            chk({tag, ".io_addr"}, oDATAIO_ADDR, addr);
            chk({tag, ".io_data"}, oDATAIO_DATA, data);
            chk({tag, ".io_pdt"}, oDATAIO_PDT, pdt);
            chk({tag, ".io_ctl"}, {oDATAIO_RW, oDATAIO_ORDER, oDATAIO_MASK},
                {rw, order, mask});
            iDATAIO_BUSY = 1'b1;
            for (int i = 0; i < mem_busy; i++) begin
                tick();
                chk({tag, ".req_hold"}, oDATAIO_REQ, 1);
                chk({tag, ".addr_hold"}, oDATAIO_ADDR, addr);
                chk({tag, ".data_hold"}, oDATAIO_DATA, data);
                chk({tag, ".ctl_hold"}, {oDATAIO_RW, oDATAIO_ORDER, oDATAIO_MASK},
                    {rw, order, mask});
            end
            iDATAIO_BUSY = 1'b0;
            tick();
            chk({tag, ".req_once"}, oDATAIO_REQ, 0);
            iDATAIO_BUSY = 1'b1;
            for (int i = 0; i < resp_delay; i++) begin
                tick();
                chk({tag, ".nv_wait"}, oNEXT_VALID, 0);
                chk({tag, ".busy_wait"}, oPREV_BUSY, 1);
            end
            iDATAIO_BUSY = 1'b0;
            iDATAIO_VALID = 1'b1;
            iDATAIO_DATA = raw;
            tick();
            iDATAIO_VALID = 1'b0;
            iDATAIO_DATA = $urandom;
        end
        chk({tag, ".nvalid"}, oNEXT_VALID, 1);
        chk({tag, ".ndata"}, oNEXT_DATA, exp_data);
        chk({tag, ".ndest"}, oNEXT_DEST, dest);
        chk({tag, ".nrw"}, oNEXT_RW, rw);
        chk({tag, ".nfault"}, oNEXT_FAULT, flt);
        iNEXT_BUSY = 1'b1;
        for (int i = 0; i < wb_busy; i++) begin
            tick();
            chk({tag, ".stall_valid"}, oNEXT_VALID, 1);
            chk({tag, ".stall_data"}, oNEXT_DATA, exp_data);
            chk({tag, ".stall_dest"}, oNEXT_DEST, dest);
        end
        iNEXT_BUSY = 1'b0;
        tick();
        chk({tag, ".exit_valid"}, oNEXT_VALID, 0);
        chk({tag, ".exit_busy"}, oPREV_BUSY, 0);
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [1:0]  r_order;
        logic [3:0]  r_mask;
        bit          r_rw;

        inRESET = 1'b0; iRESET_SYNC = 1'b0; iFLUSH = 1'b0;
        iPREV_VALID = 1'b0; iPREV_RW = 1'b0; iPREV_SIGNED = 1'b0; iPREV_DEST = '0;
        iPREV_PDT = '0; iPREV_ADDR = '0; iPREV_DATA = '0; iPREV_ORDER = '0;
        iPREV_MASK = '0; iPREV_SHIFT = '0; iDATAIO_BUSY = 1'b0; iDATAIO_VALID = 1'b0;
        iDATAIO_DATA = '0; iNEXT_BUSY = 1'b0;
        #1;
        chk("rst.busy", oPREV_BUSY, 0);
        chk("rst.req", oDATAIO_REQ, 0);
        chk("rst.nvalid", oNEXT_VALID, 0);
        chk("rst.io_addr", oDATAIO_ADDR, 0);
        chk("rst.ndata", oNEXT_DATA, 0);
        tick();
        tick();
        inRESET = 1'b1;
        tick();

        transact("ldb_s", 1'b0, 1'b1, 5'd3, 32'h0001_0000, 32'h0000_1003, 32'h0,
                 2'd0, 4'b1000, 2'd3, 32'h80AA_BBCC, 0, 0, 0);
        transact("ldh_u", 1'b0, 1'b0, 5'd7, 32'h0001_0000, 32'h0000_2002, 32'h0,
                 2'd1, 4'b1100, 2'd2, 32'h8001_1234, 0, 1, 0);
        transact("stw", 1'b1, 1'b0, 5'd9, 32'h0002_0000, 32'h0000_3000, 32'hDEAD_BEEF,
                 2'd2, 4'hF, 2'd0, 32'h1234_5678, 3, 0, 0);
        transact("misw", 1'b0, 1'b0, 5'd11, 32'h0, 32'h0000_4002, 32'h0,
                 2'd2, 4'hF, 2'd2, 32'h0, 0, 0, 0);
        transact("nomask", 1'b1, 1'b0, 5'd12, 32'h0, 32'h0000_4000, 32'h55,
                 2'd0, 4'h0, 2'd0, 32'h0, 0, 0, 0);
        transact("ldw_stall", 1'b0, 1'b0, 5'd21, 32'h0003_0000, 32'h0000_5004, 32'h0,
                 2'd2, 4'hF, 2'd0, 32'hCAFE_F00D, 1, 2, 4);

        // Flush and request together in IDLE: nothing is accepted.
        iFLUSH = 1'b1;
        iPREV_VALID = 1'b1; iPREV_ADDR = 32'h100; iPREV_ORDER = 2'd2; iPREV_MASK = 4'hF;
        tick();
        iFLUSH = 1'b0; iPREV_VALID = 1'b0;
        chk("idle_flush.busy", oPREV_BUSY, 0);
        chk("idle_flush.req", oDATAIO_REQ, 0);

        // Stray response in IDLE is ignored.
        iDATAIO_VALID = 1'b1; iDATAIO_DATA = 32'hFFFF_FFFF;
        tick();
        iDATAIO_VALID = 1'b0;
        chk("stray_resp.nvalid", oNEXT_VALID, 0);
        chk("stray_resp.busy", oPREV_BUSY, 0);

        // Flush while the request is still being refused by memory.
        iDATAIO_BUSY = 1'b1;
        present(1'b0, 1'b0, 5'd1, 32'h0, 32'h0000_0100, 32'h0, 2'd2, 4'hF, 2'd0);
        chk("flush_issue.req", oDATAIO_REQ, 1);
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0; iDATAIO_BUSY = 1'b0;
        chk("flush_issue.req_drop", oDATAIO_REQ, 0);
        chk("flush_issue.busy", oPREV_BUSY, 0);
        tick();
        chk("flush_issue.nvalid", oNEXT_VALID, 0);

        // Flush in WAIT: response still consumed, no result.
        present(1'b0, 1'b1, 5'd2, 32'h0, 32'h0000_0200, 32'h0, 2'd0, 4'b0001, 2'd0);
        tick();
        chk("flush_wait.req_done", oDATAIO_REQ, 0);
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
        chk("flush_wait.busy", oPREV_BUSY, 1);
        tick();
        iDATAIO_VALID = 1'b1; iDATAIO_DATA = 32'h0000_00FF;
        tick();
        iDATAIO_VALID = 1'b0;
        chk("flush_wait.nvalid", oNEXT_VALID, 0);
        chk("flush_wait.idle", oPREV_BUSY, 0);
        tick();
        chk("flush_wait.nvalid2", oNEXT_VALID, 0);
        transact("after_flush", 1'b0, 1'b1, 5'd4, 32'h0, 32'h0000_0201, 32'h0,
                 2'd0, 4'b0010, 2'd1, 32'h0000_9A00, 0, 0, 0);

        // Flush in DONE drops the result next cycle despite writeback stall.
        present(1'b0, 1'b0, 5'd5, 32'h0, 32'h0000_0003, 32'h0, 2'd2, 4'hF, 2'd0);
        chk("flush_done.valid", oNEXT_VALID, 1);
        iNEXT_BUSY = 1'b1; iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0; iNEXT_BUSY = 1'b0;
        chk("flush_done.drop", oNEXT_VALID, 0);
        chk("flush_done.idle", oPREV_BUSY, 0);

        // Synchronous clear while a result is stalled.
        present(1'b0, 1'b0, 5'd6, 32'h0, 32'h0000_0001, 32'h0, 2'd1, 4'b0011, 2'd0);
        iNEXT_BUSY = 1'b1; iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0; iNEXT_BUSY = 1'b0;
        chk("sync_rst.valid", oNEXT_VALID, 0);
        chk("sync_rst.dest", oNEXT_DEST, 0);
        chk("sync_rst.fault", oNEXT_FAULT, 0);
        chk("sync_rst.addr", oDATAIO_ADDR, 0);

        // Leave a non-zero result behind, then reset asynchronously in WAIT.
        transact("pre_rst", 1'b0, 1'b0, 5'd30, 32'hABCD_0000, 32'h0000_7000, 32'h0,
                 2'd2, 4'hF, 2'd0, 32'h1357_9BDF, 0, 0, 0);
        present(1'b1, 1'b0, 5'd31, 32'hABCD_0000, 32'h0000_7004, 32'h2468_ACE0,
                2'd2, 4'hF, 2'd0);
        tick();
        chk("arst.in_wait", oPREV_BUSY, 1);
        #2;
        inRESET = 1'b0;
        #1;
        chk("arst.busy", oPREV_BUSY, 0);
        chk("arst.req", oDATAIO_REQ, 0);
        chk("arst.io", oDATAIO_ADDR | oDATAIO_DATA | oDATAIO_PDT, 0);
        chk("arst.nvalid", oNEXT_VALID, 0);
        chk("arst.ndata", oNEXT_DATA, 0);
        chk("arst.ndest", oNEXT_DEST, 0);
        #2;
        inRESET = 1'b1;
        tick();
        iDATAIO_VALID = 1'b1;
        tick();
        iDATAIO_VALID = 1'b0;
        chk("arst.resp_ignored", oNEXT_VALID, 0);

        for (int n = 0; n < 30; n++) begin
            r_order = 2'($urandom_range(0, 2));
            r_addr  = $urandom & 32'hFFFF_FFFC;
            if (r_order == 2'd0) r_addr[1:0] = 2'($urandom_range(0, 3));
            if (r_order == 2'd1) r_addr[1] = 1'($urandom_range(0, 1));
            r_mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) r_addr[0] = 1'b1;
            if ($urandom_range(0, 9) == 0) r_order = 2'd3;
            if ($urandom_range(0, 9) == 0) r_mask = 4'd0;
            r_rw = 1'($urandom_range(0, 1));
            transact($sformatf("rnd%0d", n), r_rw, 1'($urandom_range(0, 1)),
                     5'($urandom), $urandom, r_addr, $urandom, r_order, r_mask,
                     r_addr[1:0], $urandom, $urandom_range(0, 2),
                     $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
